writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Shares the single reorder-buffer result-writeback port between execution units (RS/ALU, LSB, ...).
//  Picks one ready result per cycle with round-robin fairness and registers it toward the ROB.
//  Drops all in-flight results on a misprediction flush.
//  Sits between the execution units and the ROB; its wb_* outputs drive the ROB's result-write inputs.
// PARAMETERS
//  NUM_REQ    2            number of requesters; index 0 = RS, 1 = LSB
//  ROB_W      `ROB_WIDTH   width of a ROB entry id
//  DATA_W     32           result data width
// PORTS
//  clk_in       in   1               clock; rising edge
//  rst_in       in   1               reset, asynchronous, active-low
//  rdy_in       in   1               global ready; 0 = freeze all state
//  flush        in   1               misprediction flush from ROB
//  req_valid    in   NUM_REQ         requester i has a result
//  req_rob_id   in   NUM_REQ*ROB_W   ROB id per requester, packed, slice i = [i*ROB_W +: ROB_W]
//  req_data     in   NUM_REQ*DATA_W  result data per requester, packed
//  req_jump     in   NUM_REQ         result is a jump address; maps to the ROB set_jump_addr input
//  req_ready    out  NUM_REQ         result accepted this cycle
//  wb_valid     out  1               writeback valid toward ROB
//  wb_rob_id    out  ROB_W           target ROB entry
//  wb_data      out  DATA_W          result value
//  wb_jump      out  1               value is a jump target, not a register result
// BEHAVIOUR
//  - Reset (rst_in=0, async): wb_valid=0, wb_rob_id=0, wb_data=0, wb_jump=0, rr_ptr=0, skid buffers empty.
//    req_ready is forced to 0 while reset is asserted.
//  - Handshake: a transfer happens when req_valid[i] & req_ready[i] are both 1 at a rising edge.
//    A requester holds valid, rob_id, data and jump stable until that transfer.
//  - Arbitration: scan from rr_ptr upward with wrap-around; the first valid requester wins.
//    rr_ptr <= winner+1 (mod NUM_REQ) on each grant. rr_ptr is unchanged when there is no grant.
//  - Base mode (no skid):
//    - req_ready[i] = rdy_in & ~flush & (i == winner). This is combinational, same cycle.
//    - The granted result appears on wb_* at the next edge: 1-cycle latency.
//    - wb_valid=0 at the next edge when there is no grant.
//  - The ROB always accepts wb_*; wb_valid is a single-cycle pulse per result.
//  - rdy_in=0:
//    - req_ready=0, no grant.
//    - wb_*, rr_ptr and buffers hold their values.
//    - Requesters keep holding.
//  - flush=1 (only honoured when rdy_in=1):
//    - req_ready=0.
//    - wb_valid<=0 at the next edge.
//    - Skid buffers are cleared. rr_ptr is kept.
//    - A simultaneous flush and grant means flush wins: no transfer.
//  - NUM_REQ=1: arbitration degenerates to a pass-through register.
// CONFIGURATION
//  WB_ARB_SKID_EN defined:
//    - Each requester gets a 2-entry FIFO.
//    - req_ready[i] = rdy_in & ~flush & fifo_i not full. This depends only on registered state.
//    - Round-robin runs over the valid FIFO heads; the winner is popped and registered to wb_*.
//    - Latency is 2 cycles from transfer to wb_valid.
//    - Push and pop on the same full FIFO is not allowed: ready uses the pre-pop count.
//  WB_ARB_SKID_EN undefined: base mode as above, with no FIFOs.
// STRUCTURE
//  - Shared defines header: `ROB_WIDTH and the requester index constants `WB_REQ_RS=0 and `WB_REQ_LSB=1.
//  - Sub-module rr_arbiter #(N):
//    - Inputs: req[N-1:0], ptr.
//    - Outputs: one-hot grant, grant index, any_grant. Purely combinational.
//    - Instantiated once.
//  - Skid FIFOs are a generate loop inside this module; no separate module.
// TESTING
//  1. Reset: hold rst_in=0 with req_valid=2'b11 -> req_ready=0 and wb_valid=0.
//     Release reset -> first grant goes to requester 0.
//  2. Single request: req_valid=2'b01, rob_id=5, data=32'h1234 -> req_ready[0]=1 in that cycle.
//     Next cycle: wb_valid=1, wb_rob_id=5, wb_data=32'h1234, wb_jump=0.
//  3. Contention: req_valid=2'b11 held for 4 cycles, rr_ptr=0 -> grant order is 0,1,0,1.
//     Each wb_valid pulse carries the matching rob_id.
//  4. Flush: both requesters valid, flush=1 for one cycle -> req_ready=00 and wb_valid=0 next cycle.
//     The cycle after that, the grant resumes at the saved rr_ptr.
//  5. Stall: rdy_in=0 for 3 cycles with a grant pending -> no req_ready, wb_* frozen.
//     rdy_in=1 -> the pending result is granted once and not duplicated.
//  6. WB_ARB_SKID_EN: the LSB pushes 3 back-to-back results (ids 1,2,3) while the RS is continuously valid.
//     Expect: req_ready[1]=0 on the 3rd push; writebacks interleave RS/LSB; ids 1,2,3 arrive in order.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : writeback_arbiter_pkg
// Brief  : Shared defines, requester ids and helpers for the writeback arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef WB_REQ_RS
`define WB_REQ_RS 0
`endif
`ifndef WB_REQ_LSB
`define WB_REQ_LSB 1
`endif

package writeback_arbiter_pkg;

  localparam int c_fifo_depth = 2;

  typedef enum logic [0:0] {
    REQ_RS  = 1'(`WB_REQ_RS),
    REQ_LSB = 1'(`WB_REQ_LSB)
  } wb_req_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first request at or above ptr wins.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  int w_j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_j       = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(ptr) + k) % N;
      if (!any_grant && req[w_j]) begin
        grant[w_j] = 1'b1;
        grant_idx  = PTR_W'(w_j);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module : writeback_arbiter
// Brief  : Round-robin share of the ROB result-writeback port between units.
//          Optional per-requester 2-entry skid FIFOs under WB_ARB_SKID_EN.
// Rev    : 1.0  initial release
// ============================================================================
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ROB_W   = `ROB_WIDTH,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_id,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_jump,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wb_valid,
  output logic [ROB_W-1:0]          wb_rob_id,
  output logic [DATA_W-1:0]         wb_data,
  output logic                      wb_jump
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENTRY_W = 1 + ROB_W + DATA_W;

  logic               w_go;
  logic [ENTRY_W-1:0] w_in   [NUM_REQ];
  logic [ENTRY_W-1:0] w_head [NUM_REQ];
  logic [NUM_REQ-1:0] w_head_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_any_grant;
  logic               w_fire;
  logic [ENTRY_W-1:0] w_sel;
  logic [PTR_W-1:0]   r_rr_ptr;

  // Nothing may be accepted while reset is held, stalled, or flushing.
  assign w_go   = rdy_in & ~flush & rst_in;
  assign w_fire = w_go & w_any_grant;
  assign w_sel  = w_head[w_grant_idx];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
      assign w_in[i] = {req_jump[i], req_rob_id[i*ROB_W +: ROB_W], req_data[i*DATA_W +: DATA_W]};
    end
  endgenerate

`ifdef WB_ARB_SKID_EN
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_skid
      logic [ENTRY_W-1:0] r_mem [c_fifo_depth];
      logic               r_wr_ptr;
      logic               r_rd_ptr;
      logic [1:0]         r_cnt;
      logic               w_push;
      logic               w_pop;

      // Ready looks only at the pre-pop count so it never depends on the grant.
      assign req_ready[i]    = w_go & (r_cnt != 2'(c_fifo_depth));
      assign w_push          = req_valid[i] & req_ready[i];
      assign w_pop           = w_fire & w_grant[i];
      assign w_head_valid[i] = (r_cnt != 2'd0);
      assign w_head[i]       = r_mem[r_rd_ptr];

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_cnt    <= 2'd0;
          r_wr_ptr <= 1'b0;
          r_rd_ptr <= 1'b0;
          r_mem[0] <= '0;
          r_mem[1] <= '0;
        end else if (rdy_in) begin
          if (flush) begin
            r_cnt    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
          end else begin
            if (w_push) begin
              r_mem[r_wr_ptr] <= w_in[i];
              r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
              r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
              2'b10:   r_cnt <= r_cnt + 2'd1;
              2'b01:   r_cnt <= r_cnt - 2'd1;
              default: r_cnt <= r_cnt;
            endcase
          end
        end
      end
    end
  endgenerate
`else
  assign w_head       = w_in;
  assign w_head_valid = req_valid;
  assign req_ready    = {NUM_REQ{w_go}} & w_grant;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req       (w_head_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_grant (w_any_grant)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wb_valid  <= 1'b0;
      wb_rob_id <= '0;
      wb_data   <= '0;
      wb_jump   <= 1'b0;
      r_rr_ptr  <= '0;
    end else if (rdy_in) begin
      wb_valid <= w_fire;
      if (w_fire) begin
        {wb_jump, wb_rob_id, wb_data} <= w_sel;
        r_rr_ptr <= PTR_W'(rr_next(int'(w_grant_idx), NUM_REQ));
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_writeback_arbiter
// Brief  : Self-checking bench for writeback_arbiter (vector table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int RW = `ROB_WIDTH;
  localparam int DW = 32;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic            rdy_in = 1'b0;
  logic            flush  = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*RW-1:0] req_rob_id = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_jump = '0;
  logic [N-1:0]    req_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_rob_id;
  logic [DW-1:0]   wb_data;
  logic            wb_jump;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  writeback_arbiter #(.NUM_REQ(N), .ROB_W(RW), .DATA_W(DW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_rob_id (req_rob_id),
    .req_data   (req_data),
    .req_jump   (req_jump),
    .req_ready  (req_ready),
    .wb_valid   (wb_valid),
    .wb_rob_id  (wb_rob_id),
    .wb_data    (wb_data),
    .wb_jump    (wb_jump)
  );

  typedef struct {
    logic          rdy;
    logic          fl;
    logic [1:0]    valid;
    logic [1:0]    jump;
    logic [RW-1:0] id0;
    logic [DW-1:0] d0;
    logic [RW-1:0] id1;
    logic [DW-1:0] d1;
    logic [1:0]    exp_ready;
    logic          exp_wbv;
  } vec_t;

  typedef struct {
    logic [RW-1:0] id;
    logic [DW-1:0] data;
    logic          jump;
  } wb_t;

  wb_t sb[$];
  wb_t last_wb;

  function automatic vec_t mk(logic rdy, logic fl, logic [1:0] v, logic [1:0] j,
                              int id0, int d0, int id1, int d1,
                              logic [1:0] er, logic ewb);
    vec_t t;
    t.rdy = rdy; t.fl = fl; t.valid = v; t.jump = j;
    t.id0 = RW'(id0); t.d0 = DW'(d0); t.id1 = RW'(id1); t.d1 = DW'(d1);
    t.exp_ready = er; t.exp_wbv = ewb;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy_in     = v.rdy;
    flush      = v.fl;
    req_valid  = v.valid;
    req_jump   = v.jump;
    req_rob_id = {v.id1, v.id0};
    req_data   = {v.d1, v.d0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[22];
    wb_t  e;

    // rdy fl valid jump  id0 d0      id1 d1       ready wbv
    tbl[0]  = mk(1, 0, 2'b11, 2'b00,  3, 'h3333,  9, 'h9999, 2'b01, 1);
    tbl[1]  = mk(1, 0, 2'b10, 2'b00,  3, 'h3333,  9, 'h9999, 2'b10, 1);
    tbl[2]  = mk(1, 0, 2'b01, 2'b00,  5, 'h1234,  0, 0,      2'b01, 1);
    tbl[3]  = mk(1, 0, 2'b00, 2'b00,  0, 0,       0, 0,      2'b00, 0);
    tbl[4]  = mk(1, 0, 2'b10, 2'b10,  0, 0,      11, 'hB0B0, 2'b10, 1);
    tbl[5]  = mk(1, 0, 2'b11, 2'b00,  1, 'h11,    2, 'h22,   2'b01, 1);
    tbl[6]  = mk(1, 0, 2'b11, 2'b00,  3, 'h33,    2, 'h22,   2'b10, 1);
    tbl[7]  = mk(1, 0, 2'b11, 2'b00,  3, 'h33,    4, 'h44,   2'b01, 1);
    tbl[8]  = mk(1, 0, 2'b11, 2'b00,  5, 'h55,    4, 'h44,   2'b10, 1);
    tbl[9]  = mk(1, 1, 2'b11, 2'b00,  6, 'h66,    7, 'h77,   2'b00, 0);
    tbl[10] = mk(1, 0, 2'b11, 2'b00,  6, 'h66,    7, 'h77,   2'b01, 1);
    tbl[11] = mk(0, 0, 2'b11, 2'b00,  8, 'h88,    7, 'h77,   2'b00, 1);
    tbl[12] = mk(0, 0, 2'b11, 2'b00,  8, 'h88,    7, 'h77,   2'b00, 1);
    tbl[13] = mk(0, 0, 2'b11, 2'b00,  8, 'h88,    7, 'h77,   2'b00, 1);
    tbl[14] = mk(1, 0, 2'b11, 2'b00,  8, 'h88,    7, 'h77,   2'b10, 1);
    tbl[15] = mk(1, 0, 2'b01, 2'b01,  8, 'h88,    0, 0,      2'b01, 1);
    tbl[16] = mk(1, 0, 2'b00, 2'b00,  0, 0,       0, 0,      2'b00, 0);
    tbl[17] = mk(1, 1, 2'b00, 2'b00,  0, 0,       0, 0,      2'b00, 0);
    tbl[18] = mk(0, 1, 2'b11, 2'b00, 12, 'hC0,   13, 'hD0,   2'b00, 0);
    tbl[19] = mk(1, 0, 2'b11, 2'b00, 12, 'hC0,   13, 'hD0,   2'b10, 1);
    tbl[20] = mk(1, 0, 2'b01, 2'b00, 12, 'hC0,    0, 0,      2'b01, 1);
    tbl[21] = mk(1, 0, 2'b00, 2'b00,  0, 0,       0, 0,      2'b00, 0);

    last_wb.id = '0; last_wb.data = '0; last_wb.jump = 1'b0;

    // Reset held with both requesters asking
    rst_in = 1'b0; rdy_in = 1'b1; req_valid = 2'b11;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rob_id", wb_rob_id, 0);
    check("rst_wb_data", wb_data, 0);
    rst_in = 1'b1;

`ifndef WB_ARB_SKID_EN
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d_ready", i), req_ready, tbl[i].exp_ready);
      for (int r = 0; r < N; r++) begin
        if (tbl[i].valid[r] && tbl[i].exp_ready[r]) begin
          e.id   = (r == 1) ? tbl[i].id1 : tbl[i].id0;
          e.data = (r == 1) ? tbl[i].d1  : tbl[i].d0;
          e.jump = tbl[i].jump[r];
          sb.push_back(e);
        end
      end
      @(posedge clk_in);
      #1;
      check($sformatf("v%0d_wb_valid", i), wb_valid, tbl[i].exp_wbv);
      if (tbl[i].rdy && wb_valid) begin
        if (sb.size() == 0) begin
          check($sformatf("v%0d_sb_underflow", i), 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d_wb_rob_id", i), wb_rob_id, e.id);
          check($sformatf("v%0d_wb_data", i), wb_data, e.data);
          check($sformatf("v%0d_wb_jump", i), wb_jump, e.jump);
          last_wb = e;
        end
      end else if (!tbl[i].rdy) begin
        check($sformatf("v%0d_hold_rob_id", i), wb_rob_id, last_wb.id);
        check($sformatf("v%0d_hold_data", i), wb_data, last_wb.data);
      end
    end
    check("sb_drained", sb.size(), 0);

    // Asynchronous reset mid-cycle clears outputs and the round-robin pointer
    drive(mk(1, 0, 2'b01, 2'b00, 9, 'h99, 0, 0, 2'b01, 1));
    @(posedge clk_in);
    #1;
    check("pre_rst_wb_valid", wb_valid, 1);
    req_valid = 2'b00;
    #2;
    rst_in = 1'b0;
    #1;
    check("async_rst_wb_valid", wb_valid, 0);
    check("async_rst_wb_rob_id", wb_rob_id, 0);
    check("async_rst_ready", req_ready, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    drive(mk(1, 0, 2'b11, 2'b00, 10, 'hA0, 14, 'hE0, 2'b01, 1));
    #1;
    check("post_rst_ready", req_ready, 2'b01);
    @(posedge clk_in);
    #1;
    check("post_rst_wb_rob_id", wb_rob_id, 10);
    req_valid = 2'b00;
`else
    begin : skid_test
      int rs_id;
      int lsb_n;
      int attempts;
      int wb_cnt;
      logic rs_xfer;
      logic lsb_xfer;
      logic is_lsb;
      int rs_q[$];
      int lsb_q[$];
      int exp_id;
      rs_id = 8; lsb_n = 0; attempts = 0; wb_cnt = 0;
      rdy_in = 1'b1; flush = 1'b0; req_jump = '0;
      for (int c = 0; c < 40 && wb_cnt < 6; c++) begin
        req_valid[REQ_RS]  = 1'b1;
        req_valid[REQ_LSB] = (lsb_n < 3);
        req_rob_id = {RW'(lsb_n + 1), RW'(rs_id)};
        req_data   = {DW'(32'h5000 + lsb_n + 1), DW'(32'h8000 + rs_id)};
        #1;
        rs_xfer  = req_ready[REQ_RS];
        lsb_xfer = req_valid[REQ_LSB] & req_ready[REQ_LSB];
        if (req_valid[REQ_LSB]) begin
          attempts++;
          if (attempts == 3) check("skid_third_push_ready", req_ready[REQ_LSB], 0);
        end
        if (rs_xfer) rs_q.push_back(rs_id);
        if (lsb_xfer) lsb_q.push_back(lsb_n + 1);
        @(posedge clk_in);
        #1;
        if (rs_xfer) rs_id++;
        if (lsb_xfer) lsb_n++;
        if (wb_valid) begin
          is_lsb = (int'(wb_rob_id) < 8);
          check($sformatf("skid_wb%0d_source", wb_cnt), is_lsb, (wb_cnt % 2) == 1);
          if (is_lsb) begin
            exp_id = (lsb_q.size() > 0) ? lsb_q.pop_front() : -1;
            check($sformatf("skid_wb%0d_lsb_id", wb_cnt), wb_rob_id, RW'(exp_id));
            check($sformatf("skid_wb%0d_lsb_data", wb_cnt), wb_data, DW'(32'h5000 + exp_id));
          end else begin
            exp_id = (rs_q.size() > 0) ? rs_q.pop_front() : -1;
            check($sformatf("skid_wb%0d_rs_id", wb_cnt), wb_rob_id, RW'(exp_id));
          end
          wb_cnt++;
        end
      end
      check("skid_wb_count", wb_cnt, 6);
      req_valid = '0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
